// File: rtl/formula_n_pipe_aware_fsm.sv
// Sums isqrt of N_ARGS streamed arguments through one shared external pipelined isqrt.
// Latency: accept to res_vld is N_ARGS + isqrt latency. Backpressure: arg_rdy is high only while no set is being issued.
module formula_n_pipe_aware_fsm #(
  parameter int N_ARGS = 3,
  parameter int W = 32,
  localparam int RES_W = W/2 + $clog2(N_ARGS+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arg_vld,
  output logic                  arg_rdy,
  input  logic [N_ARGS*W-1:0]   args,
  output logic                  res_vld,
  output logic [RES_W-1:0]      res,
  output logic                  busy,
  output logic                  isqrt_x_vld,
  output logic [W-1:0]          isqrt_x,
  input  logic                  isqrt_y_vld,
  input  logic [W/2-1:0]        isqrt_y
);

  localparam int IW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int SN = 1 << IW;
  localparam int CW = 16;
  localparam logic [IW-1:0] LAST = IW'(N_ARGS - 1);

  logic [IW-1:0]    tx_idx_q, tx_idx_d;
  logic [IW-1:0]    rx_idx_q, rx_idx_d;
  logic [W-1:0]     arg_st_q [SN];
  logic [W-1:0]     arg_st_d [SN];
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_reg_q, res_reg_d;
  logic             res_vld_q, res_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0] sum;
  logic             accept;
  logic             final_cap;

  assign arg_rdy   = (tx_idx_q == '0) && !rst;
  assign accept    = arg_vld && arg_rdy;
  assign final_cap = isqrt_y_vld && (rx_idx_q == LAST);

  // arg[0] bypasses storage so it issues in the accept cycle itself
  always_comb begin
    isqrt_x_vld = 1'b0;
    isqrt_x     = '0;
    if (tx_idx_q == '0) begin
      isqrt_x_vld = accept;
      if (accept) isqrt_x = args[W-1:0];
    end else begin
      isqrt_x_vld = 1'b1;
      isqrt_x     = arg_st_q[tx_idx_q];
    end
  end

  always_comb begin
    tx_idx_d = tx_idx_q;
    arg_st_d = arg_st_q;
    if (tx_idx_q == '0) begin
      if (accept) begin
        for (int i = 1; i < N_ARGS; i++) arg_st_d[i] = args[i*W +: W];
        tx_idx_d = (N_ARGS == 1) ? '0 : IW'(1);
      end
    end else if (tx_idx_q == LAST) begin
      tx_idx_d = '0;
    end else begin
      tx_idx_d = tx_idx_q + IW'(1);
    end
  end

  // Receive side relies on the isqrt returning results in issue order
  always_comb begin
    sum       = ((rx_idx_q == '0) ? '0 : acc_q) + RES_W'(isqrt_y);
    rx_idx_d  = rx_idx_q;
    acc_d     = acc_q;
    res_reg_d = res_reg_q;
    res_vld_d = 1'b0;
    if (isqrt_y_vld) begin
      acc_d = sum;
      if (rx_idx_q == LAST) begin
        rx_idx_d  = '0;
        res_reg_d = sum;
        res_vld_d = 1'b1;
      end else begin
        rx_idx_d = rx_idx_q + IW'(1);
      end
    end
    cnt_d = cnt_q + CW'(accept) - CW'(final_cap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_idx_q  <= '0;
      rx_idx_q  <= '0;
      acc_q     <= '0;
      res_reg_q <= '0;
      res_vld_q <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < SN; i++) arg_st_q[i] <= '0;
    end else begin
      tx_idx_q  <= tx_idx_d;
      rx_idx_q  <= rx_idx_d;
      acc_q     <= acc_d;
      res_reg_q <= res_reg_d;
      res_vld_q <= res_vld_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < SN; i++) arg_st_q[i] <= arg_st_d[i];
    end
  end

  assign res_vld = res_vld_q;
  assign res     = res_vld_q ? res_reg_q : '0;
  assign busy    = (cnt_q != '0);

endmodule
